// File: rtl/register_file.sv
// Dual-bank RISC-V register file (32 integer + 32 FP registers) decoded from the raw instruction.
// Optional same-cycle write-to-read forwarding is enabled with `define REGFILE_WRITE_BYPASS_EN.
module register_file #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] write_data,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    logic [6:0]        w_opcode;
    logic [4:0]        w_rd;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic              w_fp_sel;
    logic              w_unused;
    logic [DATA_W-1:0] w_rd1_arr;
    logic [DATA_W-1:0] w_rd2_arr;

    logic [DATA_W-1:0] r_int [NREGS];
    logic [DATA_W-1:0] r_fp  [NREGS];

    assign w_opcode = instruction[6:0];
    assign w_rd     = instruction[11:7];
    assign w_rs1    = instruction[19:15];
    assign w_rs2    = instruction[24:20];
    assign w_unused = ^{instruction[31:25], instruction[14:12]};

    // OP-FP and the four fused multiply-add major opcodes select the FP bank
    always_comb begin
        w_fp_sel = 1'b0;
        case (w_opcode)
            7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: w_fp_sel = 1'b1;
            default: w_fp_sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_int[i] <= '0;
                r_fp[i]  <= '0;
            end
        end else if (RegWrite) begin
            if (w_fp_sel) begin
                r_fp[w_rd] <= write_data;
            end else if (w_rd != 5'd0) begin
                r_int[w_rd] <= write_data;
            end
        end
    end

    always_comb begin
        w_rd1_arr = '0;
        w_rd2_arr = '0;
        if (w_fp_sel) begin
            w_rd1_arr = r_fp[w_rs1];
            w_rd2_arr = r_fp[w_rs2];
        end else begin
            if (w_rs1 != 5'd0) w_rd1_arr = r_int[w_rs1];
            if (w_rs2 != 5'd0) w_rd2_arr = r_int[w_rs2];
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic w_byp_ok;

    // Integer x0 never forwards, so it keeps reading zero
    assign w_byp_ok = RegWrite && rst_n && (w_fp_sel || (w_rd != 5'd0));

    always_comb begin
        read_data1 = w_rd1_arr;
        read_data2 = w_rd2_arr;
        if (w_byp_ok && (w_rs1 == w_rd)) read_data1 = write_data;
        if (w_byp_ok && (w_rs2 == w_rd)) read_data2 = write_data;
    end
`else
    assign read_data1 = w_rd1_arr;
    assign read_data2 = w_rd2_arr;
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: reference bank model plus an expected-value scoreboard.
module tb_register_file;

    localparam logic [6:0] OP_INT = 7'b0110011;
    localparam logic [6:0] OP_FP  = 7'b1010011;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [63:0] write_data;
    logic        RegWrite;
    logic [63:0] read_data1;
    logic [63:0] read_data2;

    logic [63:0] m_int [32];
    logic [63:0] m_fp  [32];
    logic [63:0] exp_q [$];
    int          n_checks;
    int          n_fails;

    register_file dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instruction(instruction),
        .write_data (write_data),
        .RegWrite   (RegWrite),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [6:0] op, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, op};
    endfunction

    function automatic logic is_fp(input logic [6:0] op);
        return (op == 7'b1010011) || (op == 7'b1000011) || (op == 7'b1000111) ||
               (op == 7'b1001011) || (op == 7'b1001111);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_rd(input logic [6:0] op, input logic [4:0] idx);
        if (is_fp(op)) return m_fp[idx];
        if (idx == 5'd0) return 64'd0;
        return m_int[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_int[i] = 64'd0;
            m_fp[i]  = 64'd0;
        end
    endtask

    task automatic do_write(input logic [6:0] op, input logic [4:0] rd, input logic [63:0] data,
                            input logic we);
        @(negedge clk);
        instruction = mk_instr(op, rd, 5'd0, 5'd0);
        write_data  = data;
        RegWrite    = we;
        @(posedge clk);
        if (we) begin
            if (is_fp(op)) m_fp[rd] = data;
            else if (rd != 5'd0) m_int[rd] = data;
        end
        #1 RegWrite = 1'b0;
    endtask

    // Drive a read, queue the expected values, then sample mid-cycle and retire them
    task automatic do_read(input string tag, input logic [6:0] op, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [63:0] exp1, input logic [63:0] exp2);
        logic [63:0] e;
        @(negedge clk);
        instruction = mk_instr(op, 5'd0, rs1, rs2);
        RegWrite    = 1'b0;
        exp_q.push_back(exp1);
        exp_q.push_back(exp2);
        #1;
        e = exp_q.pop_front();
        check({tag, "_rd1"}, read_data1, e);
        e = exp_q.pop_front();
        check({tag, "_rd2"}, read_data2, e);
    endtask

    initial begin
        logic [6:0] fp_ops [5];
        n_checks    = 0;
        n_fails     = 0;
        rst_n       = 1'b0;
        instruction = 32'd0;
        write_data  = 64'd0;
        RegWrite    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        do_read("rst_int", OP_INT, 5'd5, 5'd31, 64'd0, 64'd0);
        do_read("rst_fp", OP_FP, 5'd0, 5'd17, 64'd0, 64'd0);

        do_write(OP_INT, 5'd5, 64'hDEADBEEF_CAFEBABE, 1'b1);
        do_read("t1_x5", OP_INT, 5'd5, 5'd0, 64'hDEADBEEF_CAFEBABE, 64'd0);

        do_write(OP_FP, 5'd10, 64'h40000000_00000000, 1'b1);
        do_write(OP_FP, 5'd0, 64'h3FF00000_00000000, 1'b1);
        do_read("t2_fp", OP_FP, 5'd0, 5'd10, 64'h3FF00000_00000000, 64'h40000000_00000000);
        do_read("t2_int", OP_INT, 5'd0, 5'd10, 64'd0, 64'd0);

        fp_ops[0] = 7'b1010011; fp_ops[1] = 7'b1000011; fp_ops[2] = 7'b1000111;
        fp_ops[3] = 7'b1001011; fp_ops[4] = 7'b1001111;
        for (int i = 0; i < 5; i++)
            do_read($sformatf("fpop%0d", i), fp_ops[i], 5'd10, 5'd0,
                    64'h40000000_00000000, 64'h3FF00000_00000000);

        do_write(7'b1001111, 5'd3, 64'h0000_0000_0000_0F33, 1'b1);
        do_read("fma_wr", OP_FP, 5'd3, 5'd3, model_rd(OP_FP, 5'd3), 64'h0000_0000_0000_0F33);
        do_read("fma_int_iso", OP_INT, 5'd3, 5'd5, 64'd0, 64'hDEADBEEF_CAFEBABE);

        do_write(OP_INT, 5'd5, 64'h12345678_9ABCDEF0, 1'b1);
        do_write(OP_INT, 5'd0, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
        do_read("t3", OP_INT, 5'd5, 5'd0, 64'h12345678_9ABCDEF0, 64'd0);

        do_write(OP_INT, 5'd1, 64'hBADBADBA_DBADBAD0, 1'b0);
        do_read("t4_nowe", OP_INT, 5'd1, 5'd1, 64'd0, 64'd0);

        do_write(OP_INT, 5'd1, 64'd1, 1'b1);
        do_write(OP_INT, 5'd2, 64'd2, 1'b1);
        do_write(OP_INT, 5'd3, 64'd3, 1'b1);
        do_read("t5_a", OP_INT, 5'd1, 5'd2, 64'd1, 64'd2);
        do_read("t5_b", OP_INT, 5'd2, 5'd3, 64'd2, 64'd3);

        // Reset with a write pending: reset must win
        @(negedge clk);
        rst_n       = 1'b0;
        instruction = mk_instr(OP_INT, 5'd4, 5'd0, 5'd0);
        write_data  = 64'hAAAA_AAAA_AAAA_AAAA;
        RegWrite    = 1'b1;
        @(posedge clk);
        model_reset();
        #1 begin rst_n = 1'b1; RegWrite = 1'b0; end
        do_read("t5_rst_a", OP_INT, 5'd1, 5'd2, 64'd0, 64'd0);
        do_read("t5_rst_b", OP_INT, 5'd3, 5'd4, 64'd0, 64'd0);
        do_read("t5_rst_fp", OP_FP, 5'd0, 5'd10, 64'd0, 64'd0);

        do_write(OP_INT, 5'd7, 64'h0000_0000_0000_0077, 1'b1);
        @(negedge clk);
        instruction = mk_instr(OP_INT, 5'd7, 5'd7, 5'd0);
        write_data  = 64'h7777_0000_7777_0000;
        RegWrite    = 1'b1;
`ifdef REGFILE_WRITE_BYPASS_EN
        exp_q.push_back(64'h7777_0000_7777_0000);
`else
        exp_q.push_back(64'h0000_0000_0000_0077);
`endif
        #1 check("t6_same_cycle", read_data1, exp_q.pop_front());
        check("t6_x0_port", read_data2, 64'd0);
        @(posedge clk);
        m_int[7] = 64'h7777_0000_7777_0000;
        #1 RegWrite = 1'b0;
        do_read("t6_after", OP_INT, 5'd7, 5'd7, model_rd(OP_INT, 5'd7), 64'h7777_0000_7777_0000);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
